// File: rtl/nmea_pkg.sv
// Shared types and constants for the NMEA sentence filter: FSM states,
// framing characters and the checksum digit decoder.
package nmea_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_BODY,
    ST_CS_HI,
    ST_CS_LO,
    ST_WAIT_CR,
    ST_WAIT_LF,
    ST_EMIT
  } state_t;

  localparam logic [7:0] DOLLAR = 8'h24;
  localparam logic [7:0] STAR   = 8'h2A;
  localparam logic [7:0] CR     = 8'h0D;
  localparam logic [7:0] LF     = 8'h0A;

  // Returns {valid, nibble}; lowercase hex is deliberately rejected.
  function automatic logic [4:0] hex_nibble(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
    return 5'd0;
  endfunction

endpackage

// File: rtl/nmea_line_buf.sv
// Sentence line buffer: one write port, asynchronous read port.
module nmea_line_buf #(
  parameter int MAX_LEN = 82,
  parameter int ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MAX_LEN);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we && waddr < DEPTH) mem[waddr] <= wdata;
  end

  assign rdata = (raddr < DEPTH) ? mem[raddr] : 8'h00;

endmodule

// File: rtl/nmea_sentence_filter.sv
// Frames NMEA sentences from a GPS byte stream, verifies the XOR checksum and
// forwards only intact sentences; dropped sentences are pulsed and counted.
module nmea_sentence_filter
  import nmea_pkg::*;
#(
  parameter int MAX_LEN = 82,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             good_pulse,
  output logic             bad_pulse,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  localparam int PTR_W = $clog2(MAX_LEN + 1);
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(MAX_LEN);

  state_t           state, state_n;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
  logic [7:0]       csum, csum_n;
  logic [7:0]       rx_cs, rx_cs_n;
  logic             good_n, bad_n;
  logic             buf_we;
  logic [PTR_W-1:0] buf_waddr;
  logic [7:0]       buf_rdata;
  logic [4:0]       hx;
  logic             accept, is_dollar, restart, abort;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign in_ready  = (state != ST_EMIT);
  assign out_valid = (state == ST_EMIT);
  assign out_data  = out_valid ? buf_rdata : 8'h00;
  assign accept    = in_valid & in_ready;
  assign is_dollar = (in_data == DOLLAR);
  assign hx        = hex_nibble(in_data);

  always_comb begin
    state_n   = state;
    wr_ptr_n  = wr_ptr;
    rd_ptr_n  = rd_ptr;
    csum_n    = csum;
    rx_cs_n   = rx_cs;
    good_n    = 1'b0;
    bad_n     = 1'b0;
    buf_we    = 1'b0;
    buf_waddr = wr_ptr;
    restart   = 1'b0;
    abort     = 1'b0;
    if (state == ST_EMIT) begin
      // wr_ptr holds the sentence length while emitting
      if (out_ready) begin
        if (rd_ptr == wr_ptr - 1'b1) begin
          state_n  = ST_HUNT;
          wr_ptr_n = '0;
          rd_ptr_n = '0;
        end else begin
          rd_ptr_n = rd_ptr + 1'b1;
        end
      end
    end else if (accept) begin
      if (state == ST_HUNT) begin
        restart = is_dollar;
      end else if (wr_ptr == PTR_FULL) begin
        bad_n = 1'b1;
        abort = 1'b1;
      end else begin
        buf_we   = 1'b1;
        wr_ptr_n = wr_ptr + 1'b1;
        unique case (state)
          ST_BODY: begin
            if (in_data == STAR) state_n = ST_CS_HI;
            else if (is_dollar) begin
              bad_n   = 1'b1;
              restart = 1'b1;
            end else if (in_data == CR || in_data == LF) begin
              bad_n = 1'b1;
              abort = 1'b1;
            end else csum_n = csum ^ in_data;
          end
          ST_CS_HI: begin
            if (hx[4]) begin
              rx_cs_n[7:4] = hx[3:0];
              state_n      = ST_CS_LO;
            end else begin
              bad_n   = 1'b1;
              restart = is_dollar;
              abort   = !is_dollar;
            end
          end
          ST_CS_LO: begin
            if (hx[4]) begin
              rx_cs_n[3:0] = hx[3:0];
              state_n      = ST_WAIT_CR;
            end else begin
              bad_n   = 1'b1;
              restart = is_dollar;
              abort   = !is_dollar;
            end
          end
          ST_WAIT_CR: begin
            if (in_data == CR) state_n = ST_WAIT_LF;
            else begin
              bad_n = 1'b1;
              abort = 1'b1;
            end
          end
          ST_WAIT_LF: begin
            if (in_data == LF && rx_cs == csum) begin
              good_n   = 1'b1;
              rd_ptr_n = '0;
              state_n  = ST_EMIT;
            end else begin
              bad_n = 1'b1;
              abort = 1'b1;
            end
          end
          default: ;
        endcase
      end
      // A new '$' always lands at index 0 and reopens the body
      if (restart) begin
        state_n   = ST_BODY;
        buf_we    = 1'b1;
        buf_waddr = '0;
        wr_ptr_n  = PTR_W'(1);
        csum_n    = 8'h00;
      end
      if (abort) begin
        state_n  = ST_HUNT;
        wr_ptr_n = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_HUNT;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      good_pulse <= 1'b0;
      bad_pulse  <= 1'b0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      good_pulse <= good_n;
      bad_pulse  <= bad_n;
      if (good_n) good_cnt <= sat_inc(good_cnt);
      if (bad_n)  bad_cnt  <= sat_inc(bad_cnt);
    end
  end

  always_ff @(posedge clk) begin
    csum  <= csum_n;
    rx_cs <= rx_cs_n;
  end

  nmea_line_buf #(
    .MAX_LEN (MAX_LEN),
    .ADDR_W  (PTR_W)
  ) u_line_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (buf_rdata)
  );

endmodule

// File: tb/tb_nmea_sentence_filter.sv
// Directed bench for nmea_sentence_filter with a sentence-level reference model
// and a per-cycle output scoreboard.
module tb_nmea_sentence_filter;

  localparam int MAX_LEN = 82;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             good_pulse;
  logic             bad_pulse;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] bad_cnt;

  always #5 clk = ~clk;

  nmea_sentence_filter #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .good_pulse (good_pulse),
    .bad_pulse  (bad_pulse),
    .good_cnt   (good_cnt),
    .bad_cnt    (bad_cnt)
  );

  int         n_checks = 0;
  int         n_errs   = 0;
  logic [7:0] stim_q[$];
  logic [7:0] exp_q[$];
  int         exp_good = 0, exp_bad = 0;
  int         gp_seen = 0, bp_seen = 0;
  int         xfer_cnt = 0, ir_low = 0, stall_cnt = 0;
  logic       bp_en = 1'b0;
  int         bp_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // ---------------- reference model (whole-stream, sentence level) ----------
  function automatic void app(input string s);
    for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
  endfunction

  function automatic void crlf();
    stim_q.push_back(8'h0D);
    stim_q.push_back(8'h0A);
  endfunction

  function automatic void app_rep(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(c);
  endfunction

  function automatic logic [7:0] xor_range(input int a, input int b);
    logic [7:0] x = 8'h00;
    for (int i = a; i < b; i++) x = x ^ stim_q[i];
    return x;
  endfunction

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  // Is stim_q[a..e) (starting at '$', no other '$') a well-formed sentence?
  function automatic bit frame_ok(input int a, input int e, output int last);
    int k = -1;
    int hi, lo;
    last = -1;
    for (int i = a + 1; i < e; i++)
      if (stim_q[i] == 8'h2A) begin k = i; break; end
    if (k < 0 || k + 4 >= e) return 1'b0;
    for (int i = a + 1; i < k; i++)
      if (stim_q[i] == 8'h0D || stim_q[i] == 8'h0A) return 1'b0;
    hi = hexval(stim_q[k+1]);
    lo = hexval(stim_q[k+2]);
    if (hi < 0 || lo < 0) return 1'b0;
    if (stim_q[k+3] != 8'h0D || stim_q[k+4] != 8'h0A) return 1'b0;
    if (k + 5 - a > MAX_LEN) return 1'b0;
    if (xor_range(a + 1, k) != 8'(hi * 16 + lo)) return 1'b0;
    last = k + 4;
    return 1'b1;
  endfunction

  // Each '$'-led chunk yields either one emitted sentence or one drop.
  function automatic void model_stream();
    int i = 0, j, last;
    int n = stim_q.size();
    while (i < n && stim_q[i] != 8'h24) i++;
    while (i < n) begin
      j = i + 1;
      while (j < n && stim_q[j] != 8'h24) j++;
      if (frame_ok(i, j, last)) begin
        for (int m = i; m <= last; m++) exp_q.push_back(stim_q[m]);
        exp_good++;
      end else exp_bad++;
      i = j;
    end
  endfunction

  // ---------------- drivers --------------------------------------------------
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      n_checks++;
      n_errs++;
      $display("FAIL in_ready_timeout: got 0, required 1");
    end
  endtask

  task automatic run_stream();
    model_stream();
    for (int i = 0; i < stim_q.size(); i++) send_byte(stim_q[i]);
    @(negedge clk);
    in_valid = 1'b0;
    stim_q.delete();
  endtask

  task automatic finish_test(input int hand_good, input int hand_bad);
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    #2;
    chk("good_cnt_model", good_cnt, exp_good);
    chk("bad_cnt_model", bad_cnt, exp_bad);
    chk("good_cnt_hand", good_cnt, hand_good);
    chk("bad_cnt_hand", bad_cnt, hand_bad);
    chk("good_pulses", gp_seen, exp_good);
    chk("bad_pulses", bp_seen, exp_bad);
  endtask

  initial forever begin
    @(negedge clk);
    if (bp_en) begin
      out_ready = (bp_cyc % 3 == 0);
      bp_cyc++;
    end
  end

  // ---------------- per-cycle compare ---------------------------------------
  initial begin
    logic [7:0] prev_data = 8'h00;
    logic       prev_stall = 1'b0;
    logic       prev_gp = 1'b0, prev_bp = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      chk("in_ready_vs_out_valid", in_ready, !out_valid);
      if (!in_ready) ir_low++;
      if (good_pulse) begin gp_seen++; chk("good_pulse_single", prev_gp, 0); end
      if (bad_pulse)  begin bp_seen++; chk("bad_pulse_single", prev_bp, 0); end
      if (prev_stall && out_valid) chk("stall_hold", out_data, prev_data);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL unexpected_out: got %0h, required no output", out_data);
        end else begin
          chk("out_data", out_data, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            xfer_cnt++;
          end else stall_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_gp    = good_pulse;
      prev_bp    = bad_pulse;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ------------------------------------------
  initial begin
    int ir0, base, last, t;
    bit ok;
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #7;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_good_pulse", good_pulse, 0);
    chk("rst_bad_pulse", bad_pulse, 0);
    chk("rst_good_cnt", good_cnt, 0);
    chk("rst_bad_cnt", bad_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Pin the model with hand-computed results
    app("$AB*04"); crlf();
    chk("model_xor_AB", xor_range(1, 3), 8'h03);
    ok = frame_ok(0, stim_q.size(), last);
    chk("model_bad_checksum", ok, 0);
    stim_q.delete();
    app("$A*41"); crlf();
    ok = frame_ok(0, stim_q.size(), last);
    chk("model_good_A", ok, 1);
    chk("model_good_A_last", last, 6);
    stim_q.delete();

    // Good sentence: latency and in_ready low window
    ir0 = ir_low;
    app("$A*41"); crlf();
    run_stream();
    #2;
    chk("latency_out_valid", out_valid, 1);
    chk("latency_first_byte", out_data, 8'h24);
    finish_test(1, 0);
    chk("in_ready_low_cycles", ir_low - ir0, 7);

    // Bad checksum then the corrected sentence
    app("$AB*04"); crlf();
    app("$AB*03"); crlf();
    run_stream();
    finish_test(2, 1);

    // Noise and restart on '$'
    app("xx$Q$A*41"); crlf();
    run_stream();
    finish_test(3, 2);

    // Overflow followed by a good sentence
    app("$"); app_rep("B", 90);
    app("$A*41"); crlf();
    run_stream();
    finish_test(4, 3);

    // Length boundary (82 ok, 83 dropped), empty body, lowercase hex
    app("$"); app_rep("B", 76); app("*00"); crlf();
    app("$"); app_rep("B", 77); app("*42"); crlf();
    app("$*00"); crlf();
    app("$J*4a"); crlf();
    run_stream();
    finish_test(6, 5);

    // Backpressure at 1/3 duty, second sentence held off during EMIT
    bp_cyc    = 0;
    stall_cnt = 0;
    bp_en     = 1'b1;
    app("$AB*03"); crlf();
    app("$A*41"); crlf();
    run_stream();
    finish_test(8, 5);
    chk("stalls_seen", stall_cnt > 0, 1);
    bp_en = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;

    // Reset after the third output byte
    base = xfer_cnt;
    app("$AB*03"); crlf();
    run_stream();
    t = 0;
    while (xfer_cnt < base + 3 && t < 100) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk("emit_reached_3", xfer_cnt - base, 3);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #2;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_good_cnt", good_cnt, 0);
    chk("midrst_bad_cnt", bad_cnt, 0);
    exp_good = 0;
    exp_bad  = 0;
    gp_seen  = 0;
    bp_seen  = 0;
    @(negedge clk);
    rst = 1'b0;
    app("$A*41"); crlf();
    run_stream();
    finish_test(1, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
